// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_stage_pkg : opcodes, access-size decode and lane helpers for mem_stage  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    logic  sign;
    size_e size;
  } mem_dec_t;

  function automatic mem_dec_t mem_decode(input logic [5:0] op);
    mem_dec_t d;
    d.is_mem  = 1'b0;
    d.is_load = 1'b0;
    d.sign    = 1'b0;
    d.size    = SZ_WORD;
    case (op)
      OP_LW: begin d.is_mem = 1'b1; d.is_load = 1'b1; end
      OP_SW: d.is_mem = 1'b1;
`ifdef MEM_SUBWORD_EN
      OP_LB:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sign = 1'b1; d.size = SZ_BYTE; end
      OP_LBU: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_BYTE; end
      OP_LH:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sign = 1'b1; d.size = SZ_HALF; end
      OP_LHU: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_HALF; end
      OP_SB:  begin d.is_mem = 1'b1; d.size = SZ_BYTE; end
      OP_SH:  begin d.is_mem = 1'b1; d.size = SZ_HALF; end
      OP_R_FORM: ;
`else
      // Sub-word opcodes are plain ALU results in the word-only build
      OP_R_FORM, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: ;
`endif
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_BYTE: return 1'b0;
      default: return |lo;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << lo;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] d);
    case (size)
      SZ_HALF: return {2{d[15:0]}};
      SZ_BYTE: return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// +----------------------------------------------------------------------------+
// | mem_load_align : load lane select and sign/zero extension (MEM_SUBWORD_EN) |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [5:0]  op_i,
  output logic [31:0] data_o
);

  mem_dec_t    w_dec;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        unused_ok;

  assign w_dec     = mem_decode(op_i);
  assign w_byte    = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign unused_ok = w_dec.is_mem ^ w_dec.is_load;

  always_comb begin
    data_o = rdata_i;
    case (w_dec.size)
      SZ_BYTE: data_o = {{24{w_dec.sign & w_byte[7]}}, w_byte};
      SZ_HALF: data_o = {{16{w_dec.sign & w_half[15]}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------------+
// | mem_stage : LW/SW data-bus handshake with timeout, ALU pass-through to WB   |
// | Option    : MEM_SUBWORD_EN adds LB/LBU/LH/LHU/SB/SH                         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_load,
  output logic [31:0] wb_data,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_e;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              req_q, we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        be_q;
  logic [TO_W-1:0]   cnt_q;
  logic              wb_valid_q, wb_load_q, err_mis_q, err_to_q;
  logic [31:0]       wb_data_q;

  mem_dec_t          w_dec;
  logic              w_accept;
  logic              w_misal;
  logic [31:0]       w_load_data;
  logic              unused_ok;

  assign w_dec     = mem_decode(Ins[31:26]);
  assign w_accept  = in_valid & (state_q == S_IDLE);
  assign w_misal   = misaligned(w_dec.size, Result[1:0]);
  assign unused_ok = ^{Ins[25:0], w_dec.sign};

`ifdef MEM_SUBWORD_EN
  logic [5:0] op_q;

  mem_load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op_q),
    .data_o    (w_load_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= '0;
    end else if (w_accept) begin
      op_q <= Ins[31:26];
    end
  end
`else
  assign w_load_data = dmem_rdata;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_data_q  <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_load_q  <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_dec.is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= Result;
            end else if (w_misal) begin
              err_mis_q <= 1'b1;
            end else begin
              state_q <= S_BUS;
              req_q   <= 1'b1;
              we_q    <= ~w_dec.is_load;
              addr_q  <= Result;
              wdata_q <= store_lanes(w_dec.size, Rdata2);
              be_q    <= byte_en(w_dec.size, Result[1:0]);
              cnt_q   <= '0;
            end
          end
        end
        S_BUS: begin
          // An ack on the last allowed cycle completes the access rather than timing out
          if (dmem_ack) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b1;
            wb_load_q  <= ~we_q;
            wb_data_q  <= we_q ? 32'h0 : w_load_data;
          end else if (cnt_q == c_to_last) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            err_to_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall        = (state_q == S_BUS);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_load      = wb_load_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench for mem_stage (directed vectors)           |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [1:0] K_WB  = 2'd0;
  localparam logic [1:0] K_MIS = 2'd1;
  localparam logic [1:0] K_TO  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_load, err_misalign, err_timeout;
  logic [31:0] wb_data;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          mem_lat = 0;
  int          req_cyc = 0;
  logic [31:0] mem_data = '0;
  logic        force_ack = 1'b0;
  exp_t        exp_q[$];

  mem_stage #(.TIMEOUT(15), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_load(wb_load), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Memory model: acks on the mem_lat-th cycle of an open request (0 = never)
  always @(negedge CLK) begin
    dmem_ack = force_ack;
    if (dmem_req) begin
      req_cyc++;
      if (mem_lat != 0 && req_cyc == mem_lat) begin
        dmem_ack   = 1'b1;
        dmem_rdata = mem_data;
      end
    end else begin
      req_cyc = 0;
    end
  end

  // Monitor: every writeback or error pulse must match the oldest expectation
  always @(negedge CLK) begin
    exp_t       e;
    logic [1:0] k;
    if (wb_valid || err_misalign || err_timeout) begin
      if ((int'(wb_valid) + int'(err_misalign) + int'(err_timeout)) > 1)
        chk("exclusive_pulses", {61'b0, wb_valid, err_misalign, err_timeout}, 64'h0);
      k = wb_valid ? K_WB : (err_misalign ? K_MIS : K_TO);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {61'b0, wb_valid, err_misalign, err_timeout}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", {29'b0, k, (k == K_WB) ? {wb_load, wb_data} : 33'b0},
            {29'b0, e.kind, (e.kind == K_WB) ? {e.load, e.data} : 33'b0});
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] res, input logic [31:0] d2);
    @(posedge CLK); #1;
    in_valid = 1'b1;
    Ins      = {op, 26'h0123456};
    Result   = res;
    Rdata2   = d2;
  endtask

  task automatic expect_out(input logic [1:0] kind, input logic load, input logic [31:0] data);
    exp_q.push_back('{kind: kind, load: load, data: data});
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (stall && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (stall) chk("wait_idle_bound", 64'(stall), 64'h0);
  endtask

  initial begin
    #200000;
    total_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_stall", 64'(stall), 64'h0);
    chk("reset_req", 64'(dmem_req), 64'h0);
    chk("reset_outs", {27'b0, wb_valid, wb_load, err_misalign, err_timeout, dmem_be}, 64'h0);
    chk("reset_wb_data", 64'(wb_data), 64'h0);

    // Back-to-back ALU pass-through
    send(OP_R_FORM, 32'h1234, 32'h0);       expect_out(K_WB, 1'b0, 32'h1234);
    send(OP_R_FORM, 32'h5678, 32'h0);       expect_out(K_WB, 1'b0, 32'h5678);
    send(OP_R_FORM, 32'hFFFF_FFFF, 32'h0);  expect_out(K_WB, 1'b0, 32'hFFFF_FFFF);
    idle();
    @(negedge CLK);
    chk("alu_stall", 64'(stall), 64'h0);

    // LW with ack on the 3rd request cycle; a stalled in_valid must be ignored
    mem_lat = 3; mem_data = 32'hDEAD_BEEF;
    send(OP_LW, 32'h40, 32'h0);             expect_out(K_WB, 1'b1, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    Ins = {OP_R_FORM, 26'h0}; Result = 32'h0BAD; in_valid = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge CLK);
      if (dmem_req && stall && dmem_addr == 32'h40 && !dmem_we && dmem_be == 4'hF) n++;
    end
    chk("lw_req_held_3", 64'(n), 64'd3);
    @(posedge CLK); #1 in_valid = 1'b0;
    @(negedge CLK);
    chk("lw_done_req", {62'b0, dmem_req, stall}, 64'h0);

    // SW acked in its first bus cycle
    mem_lat = 1;
    send(OP_SW, 32'h80, 32'hCAFE_F00D);     expect_out(K_WB, 1'b0, 32'h0);
    idle();
    @(negedge CLK);
    chk("sw_bus", {dmem_req, dmem_we, dmem_be, dmem_addr}, {1'b1, 1'b1, 4'hF, 32'h80});
    chk("sw_wdata", 64'(dmem_wdata), 64'hCAFE_F00D);
    wait_idle();

    // Misaligned accesses, followed immediately by an ALU op
    send(OP_SW, 32'h42, 32'h1);             expect_out(K_MIS, 1'b0, 32'h0);
    idle();
    @(negedge CLK);
    chk("sw_mis_noreq", {62'b0, dmem_req, stall}, 64'h0);
    send(OP_LW, 32'h43, 32'h0);             expect_out(K_MIS, 1'b0, 32'h0);
    send(OP_R_FORM, 32'h77, 32'h0);         expect_out(K_WB, 1'b0, 32'h77);
    idle();
    repeat (2) @(posedge CLK);

    // Timeout after 15 request cycles
    mem_lat = 0;
    send(OP_LW, 32'h100, 32'h0);            expect_out(K_TO, 1'b0, 32'h0);
    idle();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!dmem_req) break;
      n++;
    end
    chk("timeout_req_cycles", 64'(n), 64'd15);
    chk("timeout_idle", {62'b0, dmem_req, stall}, 64'h0);

    // Ack on the 15th cycle beats the timeout
    mem_lat = 15; mem_data = 32'h0BAD_F00D;
    send(OP_LW, 32'h104, 32'h0);            expect_out(K_WB, 1'b1, 32'h0BAD_F00D);
    idle();
    wait_idle();

`ifdef MEM_SUBWORD_EN
    mem_lat = 2; mem_data = 32'h0000_8000;
    send(OP_LB, 32'h41, 32'h0);             expect_out(K_WB, 1'b1, 32'hFFFF_FF80);
    idle(); wait_idle();
    send(OP_LBU, 32'h41, 32'h0);            expect_out(K_WB, 1'b1, 32'h0000_0080);
    idle(); wait_idle();
    mem_data = 32'h8001_0000;
    send(OP_LH, 32'h42, 32'h0);             expect_out(K_WB, 1'b1, 32'hFFFF_8001);
    idle(); wait_idle();
    send(OP_SB, 32'h43, 32'h0000_00AB);     expect_out(K_WB, 1'b0, 32'h0);
    idle();
    @(negedge CLK);
    chk("sb_be", 64'(dmem_be), 64'h8);
    chk("sb_wdata", 64'(dmem_wdata), 64'hABAB_ABAB);
    wait_idle();
`else
    send(OP_LB, 32'h41, 32'h0);             expect_out(K_WB, 1'b0, 32'h41);
    idle();
    @(negedge CLK);
    chk("lb_passthru_noreq", {62'b0, dmem_req, stall}, 64'h0);
`endif
    repeat (2) @(posedge CLK);

    // Reset during an open bus access, then a stray ack
    mem_lat = 0;
    send(OP_LW, 32'h200, 32'h0);
    idle();
    @(negedge CLK);
    chk("rst_test_req_open", 64'(dmem_req), 64'h1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    force_ack = 1'b1;
    @(negedge CLK);
    chk("rst_drops_req", {62'b0, dmem_req, stall}, 64'h0);
    repeat (3) @(negedge CLK);
    force_ack = 1'b0;
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
